// File: rtl/tennis_pace_ctrl.sv
// Game-step pacing and player-button front end for the tennis game core.
// Optional build macro PACE_HIT_PULSE_EN: hits becomes a one-cycle pulse in the tick cycle.
module tennis_pace_ctrl #(
    parameter int                 SPEED_W     = 26,
    parameter logic [SPEED_W-1:0] INIT_PERIOD = SPEED_W'(40000000),
    parameter int                 MIN_PERIOD  = 2,
    parameter int                 DEB_CYCLES  = 500000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         btn,
    input  logic [SPEED_W-1:0] ball_speed,
    output logic               tick,
    output logic [1:0]         hits,
    output logic [SPEED_W-1:0] period_cur,
    output logic [1:0]         btn_level
);

    localparam int                 DW    = $clog2(DEB_CYCLES + 1);
    localparam logic [SPEED_W-1:0] MIN_P = SPEED_W'(MIN_PERIOD);

    function automatic logic [SPEED_W-1:0] floor_period(input logic [SPEED_W-1:0] p);
        return (p < MIN_P) ? MIN_P : p;
    endfunction

    logic [1:0]         sync1_q, sync2_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         level_q, level_d, level_dly_q;
    logic [1:0]         rise;
    logic [1:0]         pending_q, pending_d;
    logic [1:0]         hits_q, hits_d;
    logic [SPEED_W-1:0] count_q, count_d;
    logic [SPEED_W-1:0] period_q, period_d;
    logic               tick_q, tick_d;

    // A level flips only after DEB_CYCLES consecutive mismatching samples.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign rise = level_q & ~level_dly_q;

    // A rise arriving on the reload edge starts the next window instead of being dropped.
    always_comb begin
        tick_d    = 1'b0;
        count_d   = count_q;
        period_d  = period_q;
        pending_d = pending_q | rise;
`ifdef PACE_HIT_PULSE_EN
        hits_d    = '0;
`else
        hits_d    = hits_q;
`endif
        if (enable) begin
            if (count_q == SPEED_W'(1)) begin
                tick_d    = 1'b1;
                count_d   = floor_period(ball_speed);
                period_d  = floor_period(ball_speed);
                hits_d    = pending_q;
                pending_d = rise;
            end else begin
                count_d = count_q - SPEED_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_cnt_q   <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            pending_q   <= '0;
            hits_q      <= '0;
            count_q     <= INIT_PERIOD;
            period_q    <= INIT_PERIOD;
            tick_q      <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pending_q   <= pending_d;
            hits_q      <= hits_d;
            count_q     <= count_d;
            period_q    <= period_d;
            tick_q      <= tick_d;
        end
    end

    assign tick       = tick_q;
    assign hits       = hits_q;
    assign period_cur = period_q;
    assign btn_level  = level_q;

endmodule

// File: tb/tb_tennis_pace_ctrl.sv
// Directed bench for tennis_pace_ctrl with DEB_CYCLES=4, INIT_PERIOD=10, MIN_PERIOD=2.
module tb_tennis_pace_ctrl;

    localparam int SW = 26;
`ifdef PACE_HIT_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [1:0]    btn = 2'b00;
    logic [SW-1:0] ball_speed = SW'(8);
    logic          tick;
    logic [1:0]    hits;
    logic [SW-1:0] period_cur;
    logic [1:0]    btn_level;

    int n_chk = 0;
    int n_fail = 0;

    tennis_pace_ctrl #(
        .SPEED_W    (SW),
        .INIT_PERIOD(SW'(10)),
        .MIN_PERIOD (2),
        .DEB_CYCLES (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .btn       (btn),
        .ball_speed(ball_speed),
        .tick      (tick),
        .hits      (hits),
        .period_cur(period_cur),
        .btn_level (btn_level)
    );

    always #5 clock = ~clock;

    // Leaves the bench at a falling edge with reset released: "cycle 0".
    task automatic do_reset(input logic [SW-1:0] spd);
        @(negedge clock);
        reset = 1'b1;
        btn = 2'b00;
        enable = 1'b1;
        ball_speed = spd;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(SW'(8));
        reset = 1'b1;
        #1;
        n_chk++;
        if ({tick, hits, btn_level} !== 5'b0 || period_cur !== SW'(10)) begin
            n_fail++;
            $display("FAIL reset_state: tick=%b hits=%b lvl=%b period=%0d, want 0 00 00 10",
                     tick, hits, btn_level, period_cur);
        end
        reset = 1'b0;
    endtask

    task automatic test_btn0_and_glitch();
        logic       et;
        logic [1:0] eh;
        do_reset(SW'(8));
        for (int k = 1; k <= 26; k++) begin
            btn = {(k >= 3 && k <= 5), 1'b1};
            @(posedge clock); #1;
            et = (k == 10 || k == 18 || k == 26);
            if (PULSE) eh = (k == 10) ? 2'b01 : 2'b00;
            else       eh = (k >= 10 && k < 18) ? 2'b01 : 2'b00;
            n_chk++;
            if (tick !== et || hits !== eh || btn_level !== {1'b0, k >= 6} ||
                period_cur !== ((k < 10) ? SW'(10) : SW'(8))) begin
                n_fail++;
                $display("FAIL btn0 k=%0d: tick=%b hits=%b lvl=%b period=%0d, want %b %b %b %0d",
                         k, tick, hits, btn_level, period_cur, et, eh, {1'b0, k >= 6},
                         (k < 10) ? 10 : 8);
            end
        end
    endtask

    task automatic test_both_players();
        logic [1:0] eh;
        do_reset(SW'(8));
        for (int k = 1; k <= 19; k++) begin
            btn = {(k >= 3), 1'b1};
            @(posedge clock); #1;
            if (PULSE) eh = (k == 10) ? 2'b11 : 2'b00;
            else       eh = (k >= 10 && k < 18) ? 2'b11 : 2'b00;
            n_chk++;
            if (hits !== eh) begin
                n_fail++;
                $display("FAIL both_players k=%0d: hits=%b want %b", k, hits, eh);
            end
        end
    endtask

    task automatic test_tick_collision();
        logic [1:0] eh;
        do_reset(SW'(8));
        for (int k = 1; k <= 34; k++) begin
            btn = {(k >= 12), 1'b0};
            @(posedge clock); #1;
            if (PULSE) eh = (k == 26) ? 2'b10 : 2'b00;
            else       eh = (k >= 26 && k < 34) ? 2'b10 : 2'b00;
            n_chk++;
            if (hits !== eh || btn_level !== {k >= 17, 1'b0}) begin
                n_fail++;
                $display("FAIL tick_collision k=%0d: hits=%b lvl=%b want %b %b",
                         k, hits, btn_level, eh, {k >= 17, 1'b0});
            end
        end
    endtask

    task automatic test_min_period();
        logic et;
        do_reset(SW'(0));
        for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            et = (k >= 10) && ((k - 10) % 2 == 0);
            n_chk++;
            if (tick !== et || period_cur !== ((k < 10) ? SW'(10) : SW'(2))) begin
                n_fail++;
                $display("FAIL min_period k=%0d: tick=%b period=%0d want %b %0d",
                         k, tick, period_cur, et, (k < 10) ? 10 : 2);
            end
        end
    endtask

    task automatic test_speed_change();
        logic          et;
        logic [SW-1:0] ep;
        do_reset(SW'(8));
        for (int k = 1; k <= 40; k++) begin
            if (k == 13) ball_speed = SW'(20);
            @(posedge clock); #1;
            et = (k == 10 || k == 18 || k == 38);
            ep = (k < 10) ? SW'(10) : (k < 18) ? SW'(8) : SW'(20);
            n_chk++;
            if (tick !== et || period_cur !== ep) begin
                n_fail++;
                $display("FAIL speed_change k=%0d: tick=%b period=%0d want %b %0d",
                         k, tick, period_cur, et, ep);
            end
        end
    endtask

    task automatic test_enable_gap();
        logic et;
        do_reset(SW'(8));
        for (int k = 1; k <= 24; k++) begin
            enable = !(k >= 4 && k <= 8);
            @(posedge clock); #1;
            et = (k == 15 || k == 23);
            n_chk++;
            if (tick !== et) begin
                n_fail++;
                $display("FAIL enable_gap k=%0d: tick=%b want %b", k, tick, et);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset(SW'(8));
        for (int k = 1; k <= 14; k++) begin
            btn = 2'b01;
            @(posedge clock); #1;
        end
        n_chk++;
        if (period_cur !== SW'(8) || btn_level !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_mid: period=%0d lvl=%b want 8 01", period_cur, btn_level);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({tick, hits, btn_level} !== 5'b0 || period_cur !== SW'(10)) begin
            n_fail++;
            $display("FAIL reset_mid: tick=%b hits=%b lvl=%b period=%0d want 0 00 00 10",
                     tick, hits, btn_level, period_cur);
        end
        btn = 2'b00;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock); #1;
            n_chk++;
            if (tick !== (k == 10)) begin
                n_fail++;
                $display("FAIL reset_mid_restart k=%0d: tick=%b want %b", k, tick, k == 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_btn0_and_glitch();
        test_both_players();
        test_tick_collision();
        test_min_period();
        test_speed_change();
        test_enable_gap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
